// File: rtl/tap_delay_line_pkg.sv
// Shared definitions for the tap delay line: FSM state encodings and default sizing.
// Imported by the stage register and the top level.
package tap_delay_line_pkg;

  typedef enum logic [1:0] {
    TDL_EMPTY   = 2'd0,
    TDL_FILLING = 2'd1,
    TDL_FULL    = 2'd2
  } tdl_state_e;

  localparam int TDL_DATA_W_DEF = 16;
  localparam int TDL_DEPTH_DEF  = 32;

endpackage

// File: rtl/tdl_stage.sv
// One tap of the delay line: a DATA_W register with load enable and synchronous clear.
// Reset and clear both zero the register; clear beats a simultaneous load.
module tdl_stage
  import tap_delay_line_pkg::*;
#(
  parameter int DATA_W = TDL_DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tap_delay_line.sv
// Flow-controlled tap delay line feeding the FIR multiply stage: DEPTH parallel taps,
// fill tracking with an EMPTY/FILLING/FULL FSM, and the sample shifted off the end.
module tap_delay_line
  import tap_delay_line_pkg::*;
#(
  parameter  int DATA_W = TDL_DATA_W_DEF,
  parameter  int DEPTH  = TDL_DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    hold,
  input  logic                    flush,
  output logic [DEPTH*DATA_W-1:0] taps,
  output logic                    taps_valid,
  output logic [CNT_W-1:0]        fill_count,
  output logic [DATA_W-1:0]       drop_data,
  output logic                    drop_valid
);

  logic              w_accept;
  logic [DATA_W-1:0] w_d   [DEPTH];
  logic [DATA_W-1:0] w_tap [DEPTH];

  tdl_state_e        r_state;
  logic [CNT_W-1:0]  r_fill_count;
  logic              r_taps_valid;
  logic [DATA_W-1:0] r_drop_data;
  logic              r_drop_valid;

  assign in_ready = ~hold & ~rst;
  // A flush in the same cycle discards the offered sample.
  assign w_accept = in_valid & in_ready & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_d[gi] = in_data;
      end else begin : g_body
        assign w_d[gi] = w_tap[gi-1];
      end

      tdl_stage #(
        .DATA_W(DATA_W)
      ) u_stage (
        .CLK (CLK),
        .rst (rst),
        .en  (w_accept),
        .clr (flush),
        .d   (w_d[gi]),
        .q   (w_tap[gi])
      );

      assign taps[gi*DATA_W +: DATA_W] = w_tap[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (rst || flush) begin
      r_state      <= TDL_EMPTY;
      r_fill_count <= '0;
      r_taps_valid <= 1'b0;
      r_drop_data  <= '0;
      r_drop_valid <= 1'b0;
    end else begin
      r_drop_valid <= 1'b0;
      if (w_accept) begin
        case (r_state)
          TDL_EMPTY: begin
            r_state      <= TDL_FILLING;
            r_fill_count <= CNT_W'(1);
          end
          TDL_FILLING: begin
            r_fill_count <= r_fill_count + 1'b1;
            if (r_fill_count == CNT_W'(DEPTH - 1)) begin
              r_state      <= TDL_FULL;
              r_taps_valid <= 1'b1;
            end
          end
          TDL_FULL: begin
            // The oldest tap is captured before this shift overwrites it.
            r_drop_data  <= w_tap[DEPTH-1];
            r_drop_valid <= 1'b1;
          end
          default: begin
            r_state      <= TDL_EMPTY;
            r_fill_count <= '0;
            r_taps_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign taps_valid = r_taps_valid;
  assign fill_count = r_fill_count;
  assign drop_data  = r_drop_data;
  assign drop_valid = r_drop_valid;

  a_fill_bound : assert property (@(posedge CLK) disable iff (rst)
    r_fill_count <= CNT_W'(DEPTH));
  a_valid_full : assert property (@(posedge CLK) disable iff (rst)
    r_taps_valid == (r_fill_count == CNT_W'(DEPTH)));
  a_drop_full  : assert property (@(posedge CLK) disable iff (rst)
    r_drop_valid |-> r_taps_valid);

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line: a DEPTH=4 instance for the main scenarios and a
// DEPTH=32 instance for the long ramp refill; expected values are hand-derived constants.
module tb_tap_delay_line;

  localparam int DW = 16;
  localparam int DA = 4;
  localparam int DB = 32;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  logic                 a_in_valid = 1'b0;
  logic [DW-1:0]        a_in_data  = '0;
  logic                 a_hold     = 1'b0;
  logic                 a_flush    = 1'b0;
  logic                 a_in_ready;
  logic [DA*DW-1:0]     a_taps;
  logic                 a_taps_valid;
  logic [2:0]           a_fill_count;
  logic [DW-1:0]        a_drop_data;
  logic                 a_drop_valid;

  logic                 b_in_valid = 1'b0;
  logic [DW-1:0]        b_in_data  = '0;
  logic                 b_hold     = 1'b0;
  logic                 b_flush    = 1'b0;
  logic                 b_in_ready;
  logic [DB*DW-1:0]     b_taps;
  logic                 b_taps_valid;
  logic [5:0]           b_fill_count;
  logic [DW-1:0]        b_drop_data;
  logic                 b_drop_valid;

  int n_total = 0;
  int n_bad   = 0;

  tap_delay_line #(.DATA_W(DW), .DEPTH(DA)) u_dut_a (
    .CLK        (CLK),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_data    (a_in_data),
    .in_ready   (a_in_ready),
    .hold       (a_hold),
    .flush      (a_flush),
    .taps       (a_taps),
    .taps_valid (a_taps_valid),
    .fill_count (a_fill_count),
    .drop_data  (a_drop_data),
    .drop_valid (a_drop_valid)
  );

  tap_delay_line #(.DATA_W(DW), .DEPTH(DB)) u_dut_b (
    .CLK        (CLK),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_data    (b_in_data),
    .in_ready   (b_in_ready),
    .hold       (b_hold),
    .flush      (b_flush),
    .taps       (b_taps),
    .taps_valid (b_taps_valid),
    .fill_count (b_fill_count),
    .drop_data  (b_drop_data),
    .drop_valid (b_drop_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_a_cleared(input string tag);
    chk({tag, "_taps"}, 64'(a_taps), 64'd0);
    chk({tag, "_fill"}, 64'(a_fill_count), 64'd0);
    chk({tag, "_tv"},   64'(a_taps_valid), 64'd0);
    chk({tag, "_dv"},   64'(a_drop_valid), 64'd0);
    chk({tag, "_dd"},   64'(a_drop_data), 64'd0);
  endtask

  initial begin
    int  exp_drop;
    int  n_drops;
    logic [63:0] snap;

    // 1: reset for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a_cleared("rst");
      chk("rst_ready", 64'(a_in_ready), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(a_in_ready), 64'd1);

    // 2: fill with 1..4
    a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = DW'(i);
      tick();
      $display("tx a data=%0d fill=%0d tv=%0d", i, a_fill_count, a_taps_valid);
      chk("fill_cnt", 64'(a_fill_count), 64'(i));
      chk("fill_tv", 64'(a_taps_valid), (i == 4) ? 64'd1 : 64'd0);
      chk("fill_dv", 64'(a_drop_valid), 64'd0);
    end
    chk("fill_taps", 64'(a_taps), {16'd1, 16'd2, 16'd3, 16'd4});

    // 3: one more sample drops the oldest
    a_in_data = 16'd5;
    tick();
    $display("tx a data=5 drop_valid=%0d drop_data=%0d", a_drop_valid, a_drop_data);
    chk("shift_taps", 64'(a_taps), {16'd2, 16'd3, 16'd4, 16'd5});
    chk("shift_dv", 64'(a_drop_valid), 64'd1);
    chk("shift_dd", 64'(a_drop_data), 64'd1);
    chk("shift_fill", 64'(a_fill_count), 64'd4);
    a_in_valid = 1'b0;
    tick();
    chk("pulse_dv", 64'(a_drop_valid), 64'd0);
    chk("pulse_dd_hold", 64'(a_drop_data), 64'd1);
    chk("idle_taps", 64'(a_taps), {16'd2, 16'd3, 16'd4, 16'd5});

    // 4: hold stalls the line
    a_hold     = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 16'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_ready", 64'(a_in_ready), 64'd0);
      tick();
      chk("hold_taps", 64'(a_taps), {16'd2, 16'd3, 16'd4, 16'd5});
      chk("hold_fill", 64'(a_fill_count), 64'd4);
      chk("hold_tv", 64'(a_taps_valid), 64'd1);
      chk("hold_dv", 64'(a_drop_valid), 64'd0);
    end
    a_hold = 1'b0;
    #1;
    chk("unhold_ready", 64'(a_in_ready), 64'd1);
    tick();
    $display("tx a data=6 after hold drop_data=%0d", a_drop_data);
    chk("unhold_taps", 64'(a_taps), {16'd3, 16'd4, 16'd5, 16'd6});
    chk("unhold_dv", 64'(a_drop_valid), 64'd1);
    chk("unhold_dd", 64'(a_drop_data), 64'd2);

    // 5: flush beats a simultaneous sample
    a_in_data = 16'd9;
    a_flush   = 1'b1;
    #1;
    chk("flush_ready", 64'(a_in_ready), 64'd1);
    tick();
    $display("tx a data=9 with flush fill=%0d", a_fill_count);
    chk_a_cleared("flush");
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("flush_no9", 64'(a_taps), 64'd0);

    // 6: reset mid-fill
    a_in_valid = 1'b1;
    a_in_data  = 16'd7;
    tick();
    a_in_data  = 16'd8;
    tick();
    chk("midfill_cnt", 64'(a_fill_count), 64'd2);
    chk("midfill_taps", 64'(a_taps), {16'd0, 16'd0, 16'd7, 16'd8});
    rst       = 1'b1;
    a_in_data = 16'd10;
    tick();
    chk_a_cleared("rst2");
    chk("rst2_ready", 64'(a_in_ready), 64'd0);
    a_in_valid = 1'b0;
    rst        = 1'b0;
    tick();
    chk("rst2_idle_taps", 64'(a_taps), 64'd0);

    // DEPTH=32 refill with ramp 0..40
    exp_drop   = 0;
    n_drops    = 0;
    b_in_valid = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      b_in_data = DW'(i);
      tick();
      $display("tx b data=%0d fill=%0d drop_valid=%0d drop_data=%0d",
               i, b_fill_count, b_drop_valid, b_drop_data);
      chk("ramp_dv", 64'(b_drop_valid), (i >= 32) ? 64'd1 : 64'd0);
      if (b_drop_valid) begin
        chk("ramp_dd", 64'(b_drop_data), 64'(exp_drop));
        exp_drop++;
        n_drops++;
      end
    end
    b_in_valid = 1'b0;
    chk("ramp_ndrops", 64'(n_drops), 64'd9);
    chk("ramp_fill", 64'(b_fill_count), 64'd32);
    chk("ramp_tv", 64'(b_taps_valid), 64'd1);
    for (int k = 0; k < DB; k++) begin
      snap = 64'(b_taps[k*DW +: DW]);
      chk("ramp_tap", snap, 64'(40 - k));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
